mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Iterative integer multiply/divide unit. It is the next generation of the datapath ALU: parametrised in width, and it adds signed and unsigned MUL/DIV modes with a start/busy/done handshake.
- Sits beside the execute ALU. The CPU issues one operation, stalls on `busy`, then reads the `hi`/`lo` result pair (MIPS HI/LO semantics).
- Uses a shift-add multiplier and a restoring divider, each one bit per clock.

Parameters:
- WIDTH, 16, operand width in bits; legal values 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when hi/lo become valid.
- hi  out  WIDTH  MUL: upper product half; DIV: remainder.
- lo  out  WIDTH  MUL: lower product half; DIV: quotient.
- div_by_zero  out  1  set with done for DIV/DIVU with b==0; held until next accepted start.

Behaviour:
- Reset: clock is `clock`. reset_n is asynchronous, active-low. On reset:
  - state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0.
  - Reset mid-operation abandons the operation; no done is produced.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0 latches op, a, b.
  - For signed ops, latches |a| and |b| and records the result signs: product sign = a[msb]^b[msb]; quotient sign likewise; remainder sign = a[msb].
  - Clears div_by_zero; counter=WIDTH; busy=1 from E0; next state RUN.
- RUN: one iteration per edge; counter decrements; after WIDTH iterations (edges E1..E_WIDTH), next state FIX.
  - MUL: if multiplier LSB=1, add multiplicand to the upper accumulator (WIDTH+1 bits with carry). Then shift {acc, multiplier} right by 1.
  - DIV: shift {rem, quot} left by 1; trial subtract divisor from rem. If non-negative, keep the difference and set quot LSB=1.
- FIX (edge E_WIDTH+1):
  - Apply sign correction (two's-complement negate) to the product, or to the quotient/remainder, per the recorded signs.
  - Load hi/lo; done=1 for exactly this one cycle; busy=0; next state IDLE.
- Latency: done is high WIDTH+1 edges after the start edge (17 for WIDTH=16). A new start is accepted in the done cycle (IDLE).
- start while busy is ignored; inputs are don't-care while busy.
- hi/lo hold their last result until the next FIX; they are not cleared by a new start.
- Divide by zero (b==0): normal latency; lo = all ones; hi = a (original, unsigned bits); div_by_zero=1.
- Signed overflow (DIV, a = most-negative, b = -1): lo = most-negative; hi = 0; no flag.
- Signed results: remainder takes the dividend's sign, and |rem| < |b|. Quotient truncates toward zero.
- MUL of most-negative by most-negative: magnitude arithmetic uses WIDTH+1-bit intermediates, so the 2*WIDTH-bit product is exact.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in MUL/MULU, RUN exits to FIX as soon as the remaining unshifted multiplier bits are all zero. The accumulator is realigned by the remaining shift count in FIX. Multiply latency = max(1, msb_index(|b|)+1) + 1 edges; b==0 gives 2 edges. Divide timing is unchanged.
- Undefined: fixed latency WIDTH+1 for all ops.
- Results are identical either way.

Test Plan:
- WIDTH=16, MULU a=0xFFFF b=0xFFFF, start 1 cycle -> busy from next cycle; done on edge 17; hi=0xFFFE, lo=0x0001.
- MUL a=-7 (0xFFF9) b=6 -> hi=0xFFFF, lo=0xFFD6 (-42); DIV a=-7 b=2 -> lo=0xFFFD (-3), hi=0xFFFF (-1).
- DIVU a=100 b=0 -> lo=0xFFFF, hi=0x0064, div_by_zero=1. Next DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
- DIV a=0x8000 b=0xFFFF -> lo=0x8000, hi=0x0000, div_by_zero=0; MUL 0x8000*0x8000 -> hi=0x4000, lo=0x0000.
- Handshake and reset:
  - start pulsed again at edge 5 of MULU 3*5 -> ignored; single done; lo=15.
  - start asserted in the done cycle -> accepted; back-to-back done 17 edges later.
  - reset_n low at edge 8 -> busy=0, hi=lo=0 immediately; no done.
- With MULDIV_EARLY_OUT_EN: MULU 0x1234*0x0003 -> done on edge 3, lo=0x369C, hi=0; b=0 -> done on edge 2, hi=lo=0. Without the macro: same values, done on edge 17.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiplier / restoring divider with MIPS-style hi/lo results
// Optional: MULDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are all zero.
module mul_div_unit #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic               is_div, sgn_ab, sgn_a;
  logic [WIDTH-1:0]   m_a, m_b, low;
  logic [WIDTH:0]     acc;
  logic [CNT_W-1:0]   cnt;

  logic               neg_a_in, neg_b_in, ge, last;
  logic [WIDTH-1:0]   abs_a, abs_b, quot, rem, a_back;
  logic [WIDTH:0]     sum, shl, diff;
  logic [2*WIDTH-1:0] prod_raw, prod;
`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0]   shamt;
`endif

  always_comb begin
    neg_a_in = op[0] & a[WIDTH-1];
    neg_b_in = op[0] & b[WIDTH-1];
    abs_a    = neg_a_in ? -a : a;
    abs_b    = neg_b_in ? -b : b;
    // Multiplier step: the extra accumulator bit catches the carry before the right shift.
    sum      = acc + {1'b0, (low[0] ? m_a : {WIDTH{1'b0}})};
    shl      = {acc[WIDTH-1:0], low[WIDTH-1]};
    ge       = shl >= {1'b0, m_b};
    diff     = shl - {1'b0, m_b};
    last     = (cnt == CNT_W'(1));
    prod_raw = {acc[WIDTH-1:0], low};
`ifdef MULDIV_EARLY_OUT_EN
    shamt    = CNT_W'(WIDTH) - cnt + CNT_W'(1);
    last     = last | (!is_div && ((m_b >> shamt) == '0));
    // Skipped iterations would only have shifted right; cnt still holds how many remain.
    prod_raw = prod_raw >> cnt;
`endif
    prod     = sgn_ab ? -prod_raw : prod_raw;
    quot     = sgn_ab ? -low : low;
    rem      = sgn_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    a_back   = sgn_a ? -m_a : m_a;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      is_div      <= 1'b0;
      sgn_ab      <= 1'b0;
      sgn_a       <= 1'b0;
      m_a         <= '0;
      m_b         <= '0;
      low         <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div      <= op[1];
            sgn_ab      <= neg_a_in ^ neg_b_in;
            sgn_a       <= neg_a_in;
            m_a         <= abs_a;
            m_b         <= abs_b;
            acc         <= '0;
            low         <= op[1] ? abs_a : abs_b;
            cnt         <= CNT_W'(WIDTH);
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            acc <= ge ? diff : shl;
            low <= {low[WIDTH-2:0], ge};
          end else begin
            acc <= {1'b0, sum[WIDTH:1]};
            low <= {sum[0], low[WIDTH-1:1]};
          end
          cnt <= cnt - CNT_W'(1);
          if (last) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            if (m_b == '0) begin
              lo          <= '1;
              hi          <= a_back;
              div_by_zero <= 1'b1;
            end else begin
              lo <= quot;
              hi <= rem;
            end
          end else begin
            {hi, lo} <= prod;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
